// File: rtl/ina226_pkg.sv
// Shared types and constants for the INA226-compatible I2C target.
package ina226_pkg;

    // Register pointers understood by the target.
    typedef enum logic [7:0] {
        REG_CONFIG  = 8'h00,
        REG_SHUNT_V = 8'h01,
        REG_BUS_V   = 8'h02,
        REG_POWER   = 8'h03,
        REG_CURRENT = 8'h04,
        REG_CAL     = 8'h05,
        REG_MFG_ID  = 8'hFE,
        REG_DIE_ID  = 8'hFF
    } reg_ptr_e;

    // Protocol states of the target.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT_STOP
    } target_state_e;

    localparam logic [7:0]  SLAVE_ADDR_DEF = 8'h80;
    localparam logic [15:0] CONFIG_DEF     = 16'h4127;
    localparam logic [15:0] CAL_DEF        = 16'h0000;
    localparam logic [15:0] MFG_ID_DEF     = 16'h5449;
    localparam logic [15:0] DIE_ID_DEF     = 16'h2260;

    // True for the states in which the target clocks a byte in from the initiator.
    function automatic logic isRxState(input target_state_e s);
        return (s == ST_ADDR) || (s == ST_PTR) || (s == ST_WDATA);
    endfunction

endpackage

// File: rtl/i2c_target_line_sync.sv
// SCL/SDA synchronizer and bus-event pulse generator for I2C targets.
// Pulses appear three clocks after the pin change; sda_o holds the SDA
// level that belongs to the pulse currently presented.
module i2c_target_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic sclMeta_q, sclSync_q, sclPrev_q;
    logic sdaMeta_q, sdaSync_q, sdaPrev_q;
    logic sclRise_q, sclFall_q, start_q, stop_q;

    // Two-flop synchronizer plus one delayed copy per line; an idle bus reads high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclMeta_q <= 1'b1;
            sclSync_q <= 1'b1;
            sclPrev_q <= 1'b1;
            sdaMeta_q <= 1'b1;
            sdaSync_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclMeta_q <= scl_i;
            sclSync_q <= sclMeta_q;
            sclPrev_q <= sclSync_q;
            sdaMeta_q <= sda_i;
            sdaSync_q <= sdaMeta_q;
            sdaPrev_q <= sdaSync_q;
        end
    end

    // Registered edge and START/STOP pulses, aligned with sdaPrev_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclRise_q <= 1'b0;
            sclFall_q <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            sclRise_q <= sclSync_q & ~sclPrev_q;
            sclFall_q <= ~sclSync_q & sclPrev_q;
            start_q   <= sclSync_q & sclPrev_q & sdaPrev_q & ~sdaSync_q;
            stop_q    <= sclSync_q & sclPrev_q & ~sdaPrev_q & sdaSync_q;
        end
    end

    assign sda_o      = sdaPrev_q;
    assign scl_rise_o = sclRise_q;
    assign scl_fall_o = sclFall_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;

endmodule

// File: rtl/ina226_target.sv
// I2C target presenting an INA226-compatible 16-bit register map.
// Measurement registers come from fabric inputs; config and calibration
// are writable and exported. SDA is driven open-drain through sda_oe_o.
module ina226_target
    import ina226_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR     = SLAVE_ADDR_DEF,
    parameter logic [15:0] CONFIG_DEFAULT = CONFIG_DEF,
    parameter logic [15:0] CAL_DEFAULT    = CAL_DEF,
    parameter logic [15:0] MFG_ID         = MFG_ID_DEF,
    parameter logic [15:0] DIE_ID         = DIE_ID_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe_o,
    input  logic [15:0] vshunt_i,
    input  logic [15:0] vbus_i,
    input  logic [15:0] power_i,
    input  logic [15:0] current_i,
    output logic [15:0] config_o,
    output logic [15:0] cal_o,
    output logic        reg_wr_o,
    output logic [7:0]  reg_wr_addr_o,
    output logic        busy_o
);

    logic sdaBit, sclRise, sclFall, busStart, busStop;

    i2c_target_line_sync u_line_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (sdaBit),
        .scl_rise_o (sclRise),
        .scl_fall_o (sclFall),
        .start_o    (busStart),
        .stop_o     (busStop)
    );

    target_state_e state_q;
    logic [2:0]    bitCnt_q;
    logic          byteDone_q;
    logic [7:0]    rxShift_q;
    logic [7:0]    txShift_q;
    logic [15:0]   snapshot_q;
    logic          rdLsb_q;
    logic          ackSeen_q;
    logic          rw_q;
    logic [7:0]    pointer_q;
    logic [7:0]    msbHold_q;
    logic [1:0]    byteIdx_q;
    logic [15:0]   config_q;
    logic [15:0]   cal_q;
    logic          regWr_q;
    logic [7:0]    regWrAddr_q;
    logic          busy_q;
    logic          sdaOe_q;

    logic [7:0]    rxByte_d;
    logic          lastBit_d;
    logic [15:0]   snapWord_d;
    logic [7:0]    nextTx_d;

    // Incoming byte including the bit sampled now, and whether this rise completes the byte.
    always_comb begin
        rxByte_d  = {rxShift_q[6:0], sdaBit};
        lastBit_d = sclRise && !byteDone_q && (bitCnt_q == 3'd7);
    end

    // Read map: the word a read transaction would capture for the current pointer.
    always_comb begin
        snapWord_d = 16'h0000;
        case (pointer_q)
            REG_CONFIG:  snapWord_d = config_q;
            REG_SHUNT_V: snapWord_d = vshunt_i;
            REG_BUS_V:   snapWord_d = vbus_i;
            REG_POWER:   snapWord_d = power_i;
            REG_CURRENT: snapWord_d = current_i;
            REG_CAL:     snapWord_d = cal_q;
            REG_MFG_ID:  snapWord_d = MFG_ID;
            REG_DIE_ID:  snapWord_d = DIE_ID;
            default:     snapWord_d = 16'h0000;
        endcase
    end

    // Byte to send after an initiator ACK: the halves of the snapshot alternate.
    always_comb begin
        nextTx_d = rdLsb_q ? snapshot_q[15:8] : snapshot_q[7:0];
    end

    // Protocol engine: bus conditions first, then per-state bit handling on SCL edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            bitCnt_q    <= 3'd0;
            byteDone_q  <= 1'b0;
            rxShift_q   <= 8'h00;
            txShift_q   <= 8'h00;
            snapshot_q  <= 16'h0000;
            rdLsb_q     <= 1'b0;
            ackSeen_q   <= 1'b0;
            rw_q        <= 1'b0;
            pointer_q   <= 8'h00;
            msbHold_q   <= 8'h00;
            byteIdx_q   <= 2'd0;
            config_q    <= CONFIG_DEFAULT;
            cal_q       <= CAL_DEFAULT;
            regWr_q     <= 1'b0;
            regWrAddr_q <= 8'h00;
            busy_q      <= 1'b0;
            sdaOe_q     <= 1'b0;
        end else begin
            regWr_q <= 1'b0;
            if (busStop) begin
                state_q    <= ST_IDLE;
                sdaOe_q    <= 1'b0;
                busy_q     <= 1'b0;
                bitCnt_q   <= 3'd0;
                byteDone_q <= 1'b0;
            end else if (busStart) begin
                state_q    <= ST_ADDR;
                sdaOe_q    <= 1'b0;
                bitCnt_q   <= 3'd0;
                byteDone_q <= 1'b0;
            end else begin
                if (sclRise && !byteDone_q && (isRxState(state_q) || state_q == ST_RDATA)) begin
                    bitCnt_q  <= bitCnt_q + 3'd1;
                    rxShift_q <= rxByte_d;
                    if (bitCnt_q == 3'd7) begin
                        byteDone_q <= 1'b1;
                    end
                end

                case (state_q)
                    ST_ADDR: begin
                        if (sclFall && byteDone_q) begin
                            byteDone_q <= 1'b0;
                            bitCnt_q   <= 3'd0;
                            if (rxShift_q[7:1] == SLAVE_ADDR[7:1]) begin
                                state_q <= ST_ADDR_ACK;
                                sdaOe_q <= 1'b1;
                                busy_q  <= 1'b1;
                                rw_q    <= rxShift_q[0];
                                if (rxShift_q[0]) begin
                                    snapshot_q <= snapWord_d;
                                end
                            end else begin
                                state_q <= ST_WAIT_STOP;
                                busy_q  <= 1'b0;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (sclFall) begin
                            if (rw_q) begin
                                state_q   <= ST_RDATA;
                                txShift_q <= snapshot_q[15:8];
                                sdaOe_q   <= ~snapshot_q[15];
                                rdLsb_q   <= 1'b0;
                            end else begin
                                state_q <= ST_PTR;
                                sdaOe_q <= 1'b0;
                            end
                        end
                    end

                    ST_PTR: begin
                        if (lastBit_d) begin
                            pointer_q <= rxByte_d;
                        end
                        if (sclFall && byteDone_q) begin
                            state_q    <= ST_PTR_ACK;
                            sdaOe_q    <= 1'b1;
                            byteDone_q <= 1'b0;
                            bitCnt_q   <= 3'd0;
                            byteIdx_q  <= 2'd0;
                        end
                    end

                    ST_PTR_ACK: begin
                        if (sclFall) begin
                            state_q <= ST_WDATA;
                            sdaOe_q <= 1'b0;
                        end
                    end

                    ST_WDATA: begin
                        if (lastBit_d) begin
                            case (byteIdx_q)
                                2'd0: begin
                                    msbHold_q <= rxByte_d;
                                    byteIdx_q <= 2'd1;
                                end
                                2'd1: begin
                                    byteIdx_q <= 2'd2;
                                    if (pointer_q == REG_CONFIG) begin
                                        config_q    <= {msbHold_q, rxByte_d};
                                        regWr_q     <= 1'b1;
                                        regWrAddr_q <= pointer_q;
                                    end else if (pointer_q == REG_CAL) begin
                                        cal_q       <= {msbHold_q, rxByte_d};
                                        regWr_q     <= 1'b1;
                                        regWrAddr_q <= pointer_q;
                                    end
                                end
                                default: begin
                                    byteIdx_q <= 2'd2;
                                end
                            endcase
                        end
                        if (sclFall && byteDone_q) begin
                            state_q    <= ST_WDATA_ACK;
                            sdaOe_q    <= 1'b1;
                            byteDone_q <= 1'b0;
                            bitCnt_q   <= 3'd0;
                        end
                    end

                    ST_WDATA_ACK: begin
                        if (sclFall) begin
                            state_q <= ST_WDATA;
                            sdaOe_q <= 1'b0;
                        end
                    end

                    ST_RDATA: begin
                        if (sclFall) begin
                            if (byteDone_q) begin
                                state_q    <= ST_RDATA_ACK;
                                sdaOe_q    <= 1'b0;
                                byteDone_q <= 1'b0;
                                bitCnt_q   <= 3'd0;
                                ackSeen_q  <= 1'b0;
                            end else begin
                                txShift_q <= {txShift_q[6:0], 1'b0};
                                sdaOe_q   <= ~txShift_q[6];
                            end
                        end
                    end

                    ST_RDATA_ACK: begin
                        if (sclRise) begin
                            if (sdaBit) begin
                                state_q <= ST_WAIT_STOP;
                            end else begin
                                ackSeen_q <= 1'b1;
                            end
                        end else if (sclFall && ackSeen_q) begin
                            state_q   <= ST_RDATA;
                            ackSeen_q <= 1'b0;
                            rdLsb_q   <= ~rdLsb_q;
                            txShift_q <= nextTx_d;
                            sdaOe_q   <= ~nextTx_d[7];
                        end
                    end

                    default: begin
                        sdaOe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o      = sdaOe_q;
    assign config_o      = config_q;
    assign cal_o         = cal_q;
    assign reg_wr_o      = regWr_q;
    assign reg_wr_addr_o = regWrAddr_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_ina226_target.sv
// Self-checking bench for ina226_target: an open-drain I2C initiator model
// drives directed and randomized transactions; expected values come from a
// register-map model kept in the bench.
module tb_ina226_target;

    localparam int Q = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclDrv = 1'b1;
    logic        sdaDrv = 1'b1;
    logic        sdaLine;
    logic [15:0] vshunt, vbus, power, current;
    logic        sdaOe, regWr, busy;
    logic [15:0] cfg, cal;
    logic [7:0]  regWrAddr;

    int compared = 0;
    int mismatched = 0;

    int          wrPulses = 0;
    logic [7:0]  lastWrAddr = 8'h00;

    logic [15:0] mConfig = 16'h4127;
    logic [15:0] mCal = 16'h0000;
    logic [7:0]  mPtr = 8'h00;
    int          expPulses = 0;
    logic [7:0]  expWrAddr = 8'h00;

    logic [7:0]  ptrTable [10];

    assign sdaLine = sdaDrv & ~sdaOe;

    always #5 clk = ~clk;

    ina226_target dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .scl_i         (sclDrv),
        .sda_i         (sdaLine),
        .sda_oe_o      (sdaOe),
        .vshunt_i      (vshunt),
        .vbus_i        (vbus),
        .power_i       (power),
        .current_i     (current),
        .config_o      (cfg),
        .cal_o         (cal),
        .reg_wr_o      (regWr),
        .reg_wr_addr_o (regWrAddr),
        .busy_o        (busy)
    );

    // Count write strobes and remember the address of the latest one.
    always @(posedge clk) begin
        if (regWr) begin
            wrPulses   = wrPulses + 1;
            lastWrAddr = regWrAddr;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        vshunt  = 16'($urandom);
        vbus    = 16'($urandom);
        power   = 16'($urandom);
        current = 16'($urandom);
    endtask

    function automatic logic [15:0] modelRead(input logic [7:0] p);
        case (p)
            8'h00:   return mConfig;
            8'h01:   return vshunt;
            8'h02:   return vbus;
            8'h03:   return power;
            8'h04:   return current;
            8'h05:   return mCal;
            8'hFE:   return 16'h5449;
            8'hFF:   return 16'h2260;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic i2cStart();
        sdaDrv = 1'b1; sclDrv = 1'b1; #Q;
        sdaDrv = 1'b0; #Q;
        sclDrv = 1'b0; #Q;
    endtask

    task automatic i2cRestart();
        sdaDrv = 1'b1; #Q;
        sclDrv = 1'b1; #Q;
        sdaDrv = 1'b0; #Q;
        sclDrv = 1'b0; #Q;
    endtask

    task automatic i2cStop();
        sdaDrv = 1'b0; #Q;
        sclDrv = 1'b1; #Q;
        sdaDrv = 1'b1; #(2*Q);
    endtask

    task automatic writeBit(input logic b);
        sdaDrv = b; #Q;
        sclDrv = 1'b1; #(2*Q);
        sclDrv = 1'b0; #Q;
    endtask

    task automatic readBit(output logic b);
        sdaDrv = 1'b1; #Q;
        sclDrv = 1'b1; #Q;
        b = sdaLine; #Q;
        sclDrv = 1'b0; #Q;
    endtask

    task automatic sendByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic recvByte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        writeBit(nack);
    endtask

    task automatic i2cWrite(input logic [7:0] ptr, input int nData, input logic [15:0] word,
                            input logic [7:0] extra, input bit doStop);
        logic ack;
        i2cStart();
        sendByte(8'h80, ack);
        checkOutput("write addr ack", 32'(ack), 32'h0);
        checkOutput("busy after addr ack", 32'(busy), 32'h1);
        sendByte(ptr, ack);
        checkOutput("pointer ack", 32'(ack), 32'h0);
        mPtr = ptr;
        if (nData >= 1) begin
            sendByte(word[15:8], ack);
            checkOutput("msb ack", 32'(ack), 32'h0);
        end
        if (nData >= 2) begin
            sendByte(word[7:0], ack);
            checkOutput("lsb ack", 32'(ack), 32'h0);
            if (ptr == 8'h00) begin
                mConfig = word; expPulses++; expWrAddr = ptr;
            end else if (ptr == 8'h05) begin
                mCal = word; expPulses++; expWrAddr = ptr;
            end
        end
        if (nData >= 3) begin
            sendByte(extra, ack);
            checkOutput("extra byte ack", 32'(ack), 32'h0);
        end
        if (doStop) begin
            i2cStop();
            checkOutput("busy after write stop", 32'(busy), 32'h0);
        end
        checkOutput($sformatf("config after write ptr 0x%02h", ptr), 32'(cfg), 32'(mConfig));
        checkOutput($sformatf("cal after write ptr 0x%02h", ptr), 32'(cal), 32'(mCal));
        checkOutput("reg_wr pulse count", 32'(wrPulses), 32'(expPulses));
        if (expPulses > 0) checkOutput("reg_wr_addr", 32'(lastWrAddr), 32'(expWrAddr));
    endtask

    task automatic i2cRead(input int n, input bit restart, input bit tear);
        logic ack;
        logic [7:0] d, exp;
        logic [15:0] w;
        if (restart) i2cRestart(); else i2cStart();
        sendByte(8'h81, ack);
        checkOutput("read addr ack", 32'(ack), 32'h0);
        w = modelRead(mPtr);
        for (int k = 0; k < n; k++) begin
            recvByte(k == n - 1, d);
            if (tear && k == 0) vbus = 16'hFFFF;
            exp = (k % 2 == 0) ? w[15:8] : w[7:0];
            checkOutput($sformatf("read byte %0d ptr 0x%02h", k, mPtr), 32'(d), 32'(exp));
        end
        checkOutput("sda released after nack", 32'(sdaOe), 32'h0);
        i2cStop();
        checkOutput("busy after read stop", 32'(busy), 32'h0);
    endtask

    initial begin
        logic ack, b;
        logic [7:0] d;
        int op;
        logic [7:0] p;

        ptrTable = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFE, 8'hFF, 8'h42, 8'h06};
        applyStimulus();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("reset sda_oe", 32'(sdaOe), 32'h0);
        checkOutput("reset config", 32'(cfg), 32'h4127);
        checkOutput("reset cal", 32'(cal), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset reg_wr", 32'(regWr), 32'h0);
        checkOutput("reset reg_wr_addr", 32'(regWrAddr), 32'h0);
        #(4*Q);

        // Config write, all four bytes ACKed, one strobe.
        i2cWrite(8'h00, 2, 16'h4527, 8'h00, 1'b1);
        checkOutput("config written", 32'(cfg), 32'h4527);

        // Pointer write then repeated-START read of bus voltage.
        vbus = 16'h1234;
        i2cWrite(8'h02, 0, 16'h0000, 8'h00, 1'b0);
        i2cRead(2, 1'b1, 1'b0);

        // Foreign address is NACKed and leaves the target untouched.
        i2cStart();
        sendByte(8'h90, ack);
        checkOutput("foreign addr nack", 32'(ack), 32'h1);
        checkOutput("foreign addr busy", 32'(busy), 32'h0);
        i2cStop();
        checkOutput("foreign addr config kept", 32'(cfg), 32'(mConfig));
        i2cWrite(8'h05, 2, 16'($urandom), 8'h00, 1'b1);

        // Half-written calibration word is discarded.
        i2cWrite(8'h05, 1, 16'hAB00, 8'h00, 1'b1);
        i2cWrite(8'hFF, 0, 16'h0000, 8'h00, 1'b1);
        i2cRead(2, 1'b0, 1'b0);
        i2cRead(2, 1'b0, 1'b0);

        // Snapshot holds across an input change mid-word; third byte repeats the MSB.
        vbus = 16'h1234;
        i2cWrite(8'h02, 0, 16'h0000, 8'h00, 1'b1);
        i2cRead(2, 1'b0, 1'b1);
        vbus = 16'h1234;
        i2cRead(3, 1'b0, 1'b0);

        // Randomized traffic.
        for (int it = 0; it < 14; it++) begin
            applyStimulus();
            p  = ptrTable[$urandom_range(0, 9)];
            op = $urandom_range(0, 3);
            case (op)
                0: i2cWrite(p, 2, 16'($urandom), 8'h00, 1'b1);
                1: i2cWrite(p, 3, 16'($urandom), 8'($urandom), 1'b1);
                2: begin
                    i2cWrite(p, 0, 16'h0000, 8'h00, 1'b0);
                    i2cRead(2, 1'b1, 1'b0);
                end
                default: i2cRead(3, 1'b0, 1'b0);
            endcase
        end

        // Reset while the target is driving the LSB of a read.
        vshunt = 16'h5A27;
        i2cWrite(8'h01, 0, 16'h0000, 8'h00, 1'b1);
        i2cStart();
        sendByte(8'h81, ack);
        checkOutput("pre-reset read addr ack", 32'(ack), 32'h0);
        recvByte(1'b0, d);
        checkOutput("pre-reset msb", 32'(d), 32'h5A);
        readBit(b);
        checkOutput("pre-reset lsb bit7", 32'(b), 32'h0);
        checkOutput("sda driven before reset", 32'(sdaOe), 32'h1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sda released by reset", 32'(sdaOe), 32'h0);
        checkOutput("config after reset", 32'(cfg), 32'h4127);
        checkOutput("cal after reset", 32'(cal), 32'h0);
        checkOutput("busy after reset", 32'(busy), 32'h0);
        mConfig = 16'h4127;
        mCal    = 16'h0000;
        mPtr    = 8'h00;
        sclDrv = 1'b1; #Q;
        sdaDrv = 1'b1; #Q;
        @(negedge clk) rst = 1'b0;
        #(4*Q);
        i2cRead(2, 1'b0, 1'b0);
        i2cWrite(8'h05, 2, 16'hBEEF, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
